// File: rtl/ram64_arbiter.sv
// ram64_arbiter: two-port req/ack arbiter sequencing accesses to a single RAM64.
// Round-robin by default; define RAM64_ARB_FIXED_PRIO_EN to give port 0 fixed priority.
module ram64_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state, state_n;
  logic sel, we_l, win, grant;
  assign grant = state == IDLE && (req0 || req1);
`ifdef RAM64_ARB_FIXED_PRIO_EN
  assign win = !req0;
`else
  logic rr_last;
  assign win = (req0 && req1) ? !rr_last : req1;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    ram_load = 1'b0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    busy = state != IDLE;
    if (grant) state_n = ACCESS;
    else if (state == ACCESS) state_n = ACK;
    if (state == ACCESS) ram_load = we_l;
    if (state == ACK) {ack1, ack0} = sel ? 2'b10 : 2'b01;
  end
  // address/data registers double as the RAM pins, so they hold between accesses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sel <= 1'b0;
      we_l <= 1'b0;
      ram_address <= '0;
      ram_in <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
`ifndef RAM64_ARB_FIXED_PRIO_EN
      rr_last <= 1'b1;
`endif
    end else begin
      if (grant) begin
        sel <= win;
        we_l <= win ? we1 : we0;
        ram_address <= win ? addr1 : addr0;
        ram_in <= win ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        if (!we_l && !sel) rdata0 <= ram_out;
        if (!we_l && sel) rdata1 <= ram_out;
`ifndef RAM64_ARB_FIXED_PRIO_EN
        rr_last <= sel;
`endif
      end
    end
endmodule

// File: tb/tb_ram64_arbiter.sv
// tb_ram64_arbiter: directed self-checking bench for ram64_arbiter with a behavioural RAM64.
module tb_ram64_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [5:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, ram_load, busy;
  logic [15:0] rdata0, rdata1, ram_in, ram_out;
  logic [5:0] ram_address;
  logic [15:0] mem [64] = '{default: 16'h0000};
  int checks = 0;
  int failures = 0;

  ram64_arbiter #(.DATA_W(16), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load), .ram_out(ram_out),
    .busy(busy)
  );

  always #5 clk = ~clk;
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("rst_acks", {30'd0, ack1, ack0}, 0);
    chk("rst_rdata", {rdata1, rdata0}, 0);
    chk("rst_ram", {9'd0, ram_load, ram_address, ram_in}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    @(posedge clk) #1;
  endtask

  // one complete handshake; called with the arbiter idle, 1 time unit after an edge
  task automatic acc(input bit p, input logic w, input logic [5:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd, input string tag);
    if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    @(posedge clk) #1;
    chk({tag, "_access_load"}, {31'd0, ram_load}, {31'd0, w});
    chk({tag, "_access_addr"}, {26'd0, ram_address}, {26'd0, a});
    if (w) chk({tag, "_access_in"}, {16'd0, ram_in}, {16'd0, d});
    chk({tag, "_access_busy_noack"}, {30'd0, busy, ack0 | ack1}, 32'd2);
    @(posedge clk) #1;
    chk({tag, "_ack"}, {30'd0, ack1, ack0}, p ? 32'd2 : 32'd1);
    chk({tag, "_ack_load"}, {31'd0, ram_load}, 0);
    chk({tag, "_rdata"}, {16'd0, p ? rdata1 : rdata0}, {16'd0, exp_rd});
    if (p) req1 = 0; else req0 = 0;
    @(posedge clk) #1;
    chk({tag, "_idle"}, {29'd0, busy, ack1, ack0}, 0);
  endtask

  initial begin
    bit exp0, exp1;
    do_reset();
    // single write then read on port 0
    acc(0, 1, 6'd37, 16'hBEEF, 16'h0000, "wr37");
    chk("mem37", {16'd0, mem[37]}, 32'hBEEF);
    acc(0, 0, 6'd37, 16'h0000, 16'hBEEF, "rd37");
    // contention: both ports hold write requests from reset
    do_reset();
    req0 = 1; we0 = 1; addr0 = 6'd5; wdata0 = 16'h0505;
    req1 = 1; we1 = 1; addr1 = 6'd60; wdata1 = 16'h6060;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk) #1;
`ifdef RAM64_ARB_FIXED_PRIO_EN
      exp0 = (i == 2 || i == 5 || i == 8 || i == 11);
      exp1 = (i == 14);
`else
      exp0 = (i == 2 || i == 8);
      exp1 = (i == 5 || i == 11 || i == 14);
`endif
      chk($sformatf("cont_c%0d", i), {30'd0, ack1, ack0}, {30'd0, exp1, exp0});
      if (i == 11) req0 = 0;
      if (i == 14) req1 = 0;
    end
    chk("cont_mem5", {16'd0, mem[5]}, 32'h0505);
    chk("cont_mem60", {16'd0, mem[60]}, 32'h6060);
    // a write leaves rdata untouched
    acc(1, 1, 6'd3, 16'h1234, 16'h0000, "p1wr3a");
    acc(1, 0, 6'd3, 16'h0000, 16'h1234, "p1rd3a");
    acc(1, 1, 6'd3, 16'hAAAA, 16'h1234, "p1wr3b");
    acc(1, 0, 6'd3, 16'h0000, 16'hAAAA, "p1rd3b");
    // reset during the ACCESS cycle of a write aborts it
    req0 = 1; we0 = 1; addr0 = 6'd10; wdata0 = 16'h5555;
    @(posedge clk) #1;
    chk("rstw_load_before", {31'd0, ram_load}, 1);
    #1 reset = 1'b1;
    #1;
    chk("rstw_load_after", {30'd0, busy, ram_load}, 0);
    req0 = 0;
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1;
      chk($sformatf("rstw_noack%0d", i), {30'd0, ack1, ack0}, 0);
    end
    chk("rstw_mem10", {16'd0, mem[10]}, 0);
    acc(0, 0, 6'd10, 16'h0000, 16'h0000, "rd10");
    // idle with no requests
    for (int i = 0; i < 20; i++) begin
      @(posedge clk) #1;
      chk($sformatf("idle%0d", i), {28'd0, busy, ram_load, ack1, ack0}, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram64_arbiter.md
Name: ram64_arbiter

Overview:
- Two-requester arbiter and sequencer that shares a single RAM64 (16-bit word, 6-bit address, combinational read, write on clock edge when load=1) between port 0 (CPU data side) and port 1 (loader/debug side).
- Each port uses a req/ack handshake. The block grants one access at a time and drives the RAM64 in/address/load pins.
- It registers read data back to the winning port. Default arbitration is round-robin.

Parameters:
- DATA_W, 16, word width of RAM and port data buses
- ADDR_W, 6, RAM address width (64 words)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req0  input  1  port 0 request; held with we0/addr0/wdata0 stable until ack0
- we0  input  1  port 0 write enable (1=write, 0=read)
- addr0  input  ADDR_W  port 0 word address
- wdata0  input  DATA_W  port 0 write data
- ack0  output  1  port 0 completion pulse, one cycle
- rdata0  output  DATA_W  port 0 read data, valid while ack0=1 for reads
- req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
- ram_in  output  DATA_W  to RAM64 in
- ram_address  output  ADDR_W  to RAM64 address
- ram_load  output  1  to RAM64 load
- ram_out  input  DATA_W  from RAM64 out
- busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state=IDLE, ack0=ack1=0, rdata0=rdata1=0, ram_load=0, ram_address=0, ram_in=0, busy=0, rr_last=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - req0 and req1 are sampled only in this state.
  - If no request is present, the FSM stays in IDLE.
  - If exactly one request is present, that port wins.
  - If both are present, the winner is the port != rr_last.
  - On a win: latch sel, we, addr, wdata into internal registers; go to ACCESS.
- ACCESS (1 cycle):
  - ram_address=addr_latched and ram_in=wdata_latched, both driven from registers.
  - ram_load = we_latched, asserted for this cycle only.
  - On a read, rdata[sel] captures ram_out at the closing edge.
  - On a write, rdata[sel] is not updated and holds its previous value.
  - rr_last <= sel. Next state is ACK.
- ACK (1 cycle):
  - ack[sel]=1; the other ack stays 0; ram_load=0. Next state is IDLE.
- Latency and throughput:
  - req sampled at edge k → ACCESS during cycle k+1 → ack during cycle k+2.
  - Maximum throughput is one access per 3 cycles.
- Requester rule: drop req in the cycle after seeing ack. If req is still high when IDLE samples it, that is a new request.
- ram_address and ram_in hold their last values in IDLE/ACK. ram_load is 0 outside ACCESS.
- acks are mutually exclusive and never asserted in consecutive cycles.
- Reset mid-operation: asynchronously forces the reset values. A write in ACCESS is aborted with no RAM update. A pending ack is lost, so requesters must re-issue.
- A req that drops before it is granted is ignored. No grant is issued for a port whose req was low at the IDLE sample.

Optional Feature:
- Macro: RAM64_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports request. rr_last is neither used nor implemented.
- Undefined (default): round-robin as described above.

Test Plan:
- Single write then read on port 0: req0/we0=1/addr0=6'd37/wdata0=16'hBEEF, then a read of addr 37 → ram_load high exactly one cycle; ack0 pulses at k+2 for each access; rdata0=16'hBEEF on the read ack.
- Contention round-robin: req0 and req1 both held from reset (writes to addr 5 and addr 60) → grants in order port0, port1, port0, port1; ack0/ack1 alternate every 3 cycles; ack1 never coincides with ack0.
- Write does not touch rdata: read addr 3 (value 16'h1234) on port 1, then write 16'hAAAA to addr 3 → rdata1 stays 16'h1234 through the write ack; a subsequent read returns 16'hAAAA.
- Reset mid-write: assert reset during ACCESS of a write of 16'h5555 to addr 10 (previously 0) → ram_load falls immediately; ack never pulses; a later read of addr 10 returns 16'h0000.
- Idle behaviour: no req for 20 cycles → busy=0, ram_load=0, ack0=ack1=0 throughout.
- With RAM64_ARB_FIXED_PRIO_EN defined, both reqs held continuously → port 0 granted every time; ack1 never asserts until req0 drops.
